// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing for the five-stage core: per-stage go/clear strobes and pc_en
// covering load-use stalls, redirect flushes and syscall halt/resume. Optional perf counters: HAZ_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
    parameter int LOAD_STALL = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_redirect,
    input  logic             id_halt,
    input  logic             resume,
    output logic             pc_en,
    output logic             if_id_go,
    output logic             if_id_clear,
    output logic             id_ex_go,
    output logic             id_ex_clear,
    output logic             ex_mem_go,
    output logic             mem_wb_go,
    output logic             halted,
    output logic [1:0]       state
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_HALT  = 2'b10
    } state_t;

    localparam logic [2:0] STALL_INIT  = 3'(LOAD_STALL - 1);
    localparam logic       MULTI_STALL = (LOAD_STALL > 1);

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       resumed_q, resumed_d;
    logic       hazard;

    assign hazard = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));

    assign state  = state_q;
    assign halted = (state_q == ST_HALT);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        resumed_d   = 1'b0;
        pc_en       = 1'b1;
        if_id_go    = 1'b1;
        if_id_clear = 1'b0;
        id_ex_go    = 1'b1;
        id_ex_clear = 1'b0;
        ex_mem_go   = 1'b1;
        mem_wb_go   = 1'b1;
        case (state_q)
            ST_RUN: begin
                if (ex_redirect) begin
                    if_id_clear = 1'b1;
                    id_ex_clear = 1'b1;
                end else if (hazard) begin
                    pc_en       = 1'b0;
                    if_id_go    = 1'b0;
                    id_ex_clear = 1'b1;
                    cnt_d       = STALL_INIT;
                    if (MULTI_STALL) state_d = ST_STALL;
                end else if (id_halt && !resumed_q) begin
                    // The halt op itself moves on to EX; younger fetches are held.
                    pc_en    = 1'b0;
                    if_id_go = 1'b0;
                    state_d  = ST_HALT;
                end
            end
            ST_STALL: begin
                if (ex_redirect) begin
                    if_id_clear = 1'b1;
                    id_ex_clear = 1'b1;
                    cnt_d       = 3'd0;
                    state_d     = ST_RUN;
                end else begin
                    pc_en       = 1'b0;
                    if_id_go    = 1'b0;
                    id_ex_clear = 1'b1;
                    cnt_d       = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) state_d = ST_RUN;
                end
            end
            ST_HALT: begin
                pc_en       = 1'b0;
                if_id_go    = 1'b0;
                id_ex_clear = 1'b1;
                // The halt op is still in ID on exit, so the first RUN cycle ignores id_halt.
                if (resume) begin
                    state_d   = ST_RUN;
                    resumed_d = 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
        if (rst) begin
            pc_en       = 1'b0;
            if_id_go    = 1'b0;
            if_id_clear = 1'b1;
            id_ex_go    = 1'b0;
            id_ex_clear = 1'b1;
            ex_mem_go   = 1'b0;
            mem_wb_go   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            cnt_q     <= 3'd0;
            resumed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            resumed_q <= resumed_d;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_en && (state_q != ST_HALT) && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 1'b1;
        if (ex_redirect && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (LOAD_STALL=1 and 3) on shared inputs,
// checked every cycle against a behavioural model plus directed literal expectations.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rd;
    logic       id_uses_rs, id_uses_rt, ex_mem_read, ex_redirect, id_halt, resume;

    logic       a_pc_en, a_ifg, a_ifc, a_idg, a_idc, a_exg, a_wbg, a_halted;
    logic [1:0] a_state;
    logic       b_pc_en, b_ifg, b_ifc, b_idg, b_idc, b_exg, b_wbg, b_halted;
    logic [1:0] b_state;
`ifdef HAZ_PERF_CNT_EN
    logic [15:0] a_stall_cnt, a_flush_cnt, b_stall_cnt, b_flush_cnt;
`endif

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.LOAD_STALL(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
        .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .ex_redirect(ex_redirect), .id_halt(id_halt), .resume(resume),
        .pc_en(a_pc_en), .if_id_go(a_ifg), .if_id_clear(a_ifc), .id_ex_go(a_idg),
        .id_ex_clear(a_idc), .ex_mem_go(a_exg), .mem_wb_go(a_wbg), .halted(a_halted),
        .state(a_state)
`ifdef HAZ_PERF_CNT_EN
        , .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
`endif
    );

    pipeline_hazard_ctrl #(.LOAD_STALL(3), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
        .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .ex_redirect(ex_redirect), .id_halt(id_halt), .resume(resume),
        .pc_en(b_pc_en), .if_id_go(b_ifg), .if_id_clear(b_ifc), .id_ex_go(b_idg),
        .id_ex_clear(b_idc), .ex_mem_go(b_exg), .mem_wb_go(b_wbg), .halted(b_halted),
        .state(b_state)
`ifdef HAZ_PERF_CNT_EN
        , .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
`endif
    );

    logic [9:0] got_a, got_b;
    assign got_a = {a_pc_en, a_ifg, a_ifc, a_idg, a_idc, a_exg, a_wbg, a_halted, a_state};
    assign got_b = {b_pc_en, b_ifg, b_ifc, b_idg, b_idc, b_exg, b_wbg, b_halted, b_state};

    // Model: remaining stall cycles, halted flag, and "just resumed" flag per instance.
    int m_left[2];
    bit m_halt[2];
    bit m_res[2];
    int m_stall[2];
    int m_flush[2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_left[i] = 0; m_halt[i] = 0; m_res[i] = 0; m_stall[i] = 0; m_flush[i] = 0;
        end
    end

    function automatic int stall_len(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic bit haz_now();
        return ex_mem_read && (ex_rd != 0) &&
               ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
    endfunction

    // Strobe order: pc_en, if_id_go, if_id_clear, id_ex_go, id_ex_clear, ex_mem_go, mem_wb_go
    function automatic logic [9:0] model_out(input int left, input bit hlt, input bit res);
        logic [6:0] s;
        logic [1:0] st;
        st = hlt ? 2'd2 : (left > 0 ? 2'd1 : 2'd0);
        if (hlt)                     s = 7'b0001111;
        else if (ex_redirect)        s = 7'b1111111;
        else if (left > 0)           s = 7'b0001111;
        else if (haz_now())          s = 7'b0001111;
        else if (id_halt && !res)    s = 7'b0001011;
        else                         s = 7'b1101011;
        if (rst) s = 7'b0010100;
        return {s, hlt, st};
    endfunction

    always @(posedge clk) begin
        started <= 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_left[i] <= 0; m_halt[i] <= 0; m_res[i] <= 0;
                m_stall[i] <= 0; m_flush[i] <= 0;
            end else begin
                if (!model_out(m_left[i], m_halt[i], m_res[i])[9] && !m_halt[i] && m_stall[i] < 65535)
                    m_stall[i] <= m_stall[i] + 1;
                if (ex_redirect && m_flush[i] < 65535)
                    m_flush[i] <= m_flush[i] + 1;
                m_res[i] <= 0;
                if (m_halt[i]) begin
                    if (resume) begin
                        m_halt[i] <= 0;
                        m_res[i]  <= 1;
                    end
                end else if (m_left[i] > 0) begin
                    m_left[i] <= ex_redirect ? 0 : m_left[i] - 1;
                end else if (ex_redirect) begin
                    m_left[i] <= 0;
                end else if (haz_now()) begin
                    m_left[i] <= stall_len(i) - 1;
                end else if (id_halt && !m_res[i]) begin
                    m_halt[i] <= 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 2; i++) begin
                logic [9:0] exp_v, got_v;
                exp_v = model_out(m_left[i], m_halt[i], m_res[i]);
                got_v = (i == 0) ? got_a : got_b;
                checks++;
                if (got_v !== exp_v) begin
                    errors++;
                    $display("FAIL model_cmp dut%0d t=%0t got=%b exp=%b", i, $time, got_v, exp_v);
                end
`ifdef HAZ_PERF_CNT_EN
                checks++;
                if (((i == 0) ? a_stall_cnt : b_stall_cnt) !== 16'(m_stall[i]) ||
                    ((i == 0) ? a_flush_cnt : b_flush_cnt) !== 16'(m_flush[i])) begin
                    errors++;
                    $display("FAIL perf_cmp dut%0d t=%0t stall=%0d/%0d flush=%0d/%0d", i, $time,
                             (i == 0) ? a_stall_cnt : b_stall_cnt, m_stall[i],
                             (i == 0) ? a_flush_cnt : b_flush_cnt, m_flush[i]);
                end
`endif
            end
        end
    end

    task automatic lit(input string name, input logic [15:0] got, input logic [15:0] exp_v);
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp_v);
        end
    endtask

    task automatic idle();
        rst = 0; id_rs = 0; id_rt = 0; ex_rd = 0; id_uses_rs = 0; id_uses_rt = 0;
        ex_mem_read = 0; ex_redirect = 0; id_halt = 0; resume = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic load_use();
        ex_mem_read = 1; ex_rd = 5'd8; id_rs = 5'd8; id_uses_rs = 1;
    endtask

    // {ex_mem_read, id_uses_rs, id_uses_rt, id_rs, id_rt, ex_rd}
    logic [17:0] tbl [6];

    initial begin
        tbl[0] = {3'b101, 5'd1, 5'd5, 5'd5};
        tbl[1] = {3'b100, 5'd1, 5'd5, 5'd5};
        tbl[2] = {3'b011, 5'd5, 5'd5, 5'd5};
        tbl[3] = {3'b110, 5'd31, 5'd2, 5'd31};
        tbl[4] = {3'b111, 5'd0, 5'd0, 5'd0};
        tbl[5] = {3'b110, 5'd3, 5'd3, 5'd4};

        idle();
        rst = 1;
        @(negedge clk);
        lit("rst_state", 16'(a_state), 16'd0);
        lit("rst_pc_en", 16'(a_pc_en), 16'd0);
        lit("rst_if_id_clear", 16'(b_ifc), 16'd1);
        lit("rst_ex_mem_go", 16'(b_exg), 16'd0);
        next_cycle(); rst = 1;
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        lit("run_after_rst", 16'(got_a[9:3]), 16'b1101011);

        next_cycle(); load_use();
        @(negedge clk);
        lit("ls1_pc_en", 16'(a_pc_en), 16'd0);
        lit("ls1_if_id_go", 16'(a_ifg), 16'd0);
        lit("ls1_id_ex_clear", 16'(a_idc), 16'd1);
        next_cycle();
        @(negedge clk);
        lit("ls1_back_run", 16'(a_pc_en), 16'd1);
        lit("ls3_cyc2_state", 16'(b_state), 16'd1);
        lit("ls3_cyc2_pc_en", 16'(b_pc_en), 16'd0);
        next_cycle();
        @(negedge clk);
        lit("ls3_cyc3_state", 16'(b_state), 16'd1);
        next_cycle();
        @(negedge clk);
        lit("ls3_done_pc_en", 16'(b_pc_en), 16'd1);
        lit("ls3_done_state", 16'(b_state), 16'd0);

        next_cycle(); ex_mem_read = 1; ex_rd = 0; id_rt = 0; id_uses_rt = 1;
        @(negedge clk);
        lit("rd0_no_stall", 16'(b_pc_en), 16'd1);

        next_cycle(); load_use(); id_halt = 1; ex_redirect = 1;
        @(negedge clk);
        lit("redir_wins", 16'({b_pc_en, b_ifc, b_idc, b_state}), 16'b11100);

        next_cycle(); load_use();
        @(negedge clk);
        next_cycle(); ex_redirect = 1;
        @(negedge clk);
        lit("stall_redir_flush", 16'({b_pc_en, b_ifc, b_idc}), 16'b111);
        next_cycle();
        @(negedge clk);
        lit("stall_redir_run", 16'(b_state), 16'd0);

        next_cycle(); id_halt = 1;
        @(negedge clk);
        lit("halt_pass_op", 16'({a_pc_en, a_idg, a_idc}), 16'b010);
        for (int k = 0; k < 3; k++) begin
            next_cycle(); id_halt = 1;
            @(negedge clk);
            lit("halt_hold", 16'({b_halted, b_state, b_pc_en}), 16'b1100);
        end
        next_cycle(); id_halt = 1; resume = 1;
        @(negedge clk);
        lit("halt_resume_cyc", 16'(a_pc_en), 16'd0);
        next_cycle(); id_halt = 1; resume = 1;
        @(negedge clk);
        lit("resumed_plain_run", 16'({a_pc_en, a_state}), 16'b100);
        next_cycle(); resume = 1;
        @(negedge clk);
        lit("resume_held", 16'({b_pc_en, b_halted}), 16'b10);

        next_cycle(); load_use();
        @(negedge clk);
        next_cycle(); rst = 1;
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        lit("rst_mid_stall", 16'({b_pc_en, b_state}), 16'b100);

        for (int t = 0; t < 6; t++) begin
            next_cycle();
            {ex_mem_read, id_uses_rs, id_uses_rt, id_rs, id_rt, ex_rd} = tbl[t];
            @(negedge clk);
            repeat (3) begin
                next_cycle();
                @(negedge clk);
            end
        end

`ifdef HAZ_PERF_CNT_EN
        next_cycle(); rst = 1;
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        next_cycle(); load_use();
        @(negedge clk);
        repeat (3) begin
            next_cycle();
            @(negedge clk);
        end
        next_cycle(); ex_redirect = 1;
        @(negedge clk);
        next_cycle(); ex_redirect = 1;
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        lit("perf_stall3", b_stall_cnt, 16'd3);
        lit("perf_flush2", b_flush_cnt, 16'd2);
        lit("perf_stall1", a_stall_cnt, 16'd1);
`endif

        next_cycle();
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
